inst_fetch: RTL and testbench

Instruction fetch stage for the MIPS core. Generates the PC, requests instructions through the SRAM-like instruction port, and buffers returned words in a 2-entry FIFO. It presents them to the decode stage, split into the op_code/rt/funct fields that the control decoder consumes. Handles branch/exception redirects, including discarding a response still in flight, and flags misaligned fetch addresses.

---
 rtl/inst_fetch.sv | 160 ++++++++++++++++
 tb/tb_inst_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, SRAM-like instruction request port,
// 2-entry return buffer and decode-side field split, with redirect/discard handling.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [5:0]  id_op_code,
  output logic [4:0]  id_rt,
  output logic [5:0]  id_funct,
  output logic        id_adel
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  count_q, count_d;
  logic        discard_q, discard_d;
  entry_t      fifo_q [2];
  entry_t      push_entry;
  logic        push, pop;

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    push       = 1'b0;
    push_entry = '0;
    pop        = (count_q != 2'd0) && id_ready && !redirect_valid;

    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (count_q < 2'd2) begin
          if (pc_q[1:0] == 2'b00) begin
            state_d    = S_REQ;
            req_addr_d = pc_q;
          end else begin
            state_d    = S_HALT;
            push       = 1'b1;
            push_entry = '{pc: pc_q, inst: 32'h0, adel: 1'b1};
          end
        end
      end
      S_REQ: begin
        // The address must stay held until accepted, so a redirect here only
        // retargets pc and marks the in-flight word for discard.
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
        if (inst_addr_ok) begin
          state_d = S_WAIT;
          if (!redirect_valid && !discard_q) pc_d = req_addr_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (inst_data_ok) begin
          discard_d = 1'b0;
          if (redirect_valid) begin
            state_d = S_IDLE;
          end else if (!discard_q) begin
            push       = 1'b1;
            push_entry = '{pc: req_addr_q, inst: inst_rdata, adel: 1'b0};
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      S_HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid)    count_d = 2'd0;
    else if (push && !pop) count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
    else                   count_d = count_q;

    // Back-to-back fetch only when the buffer keeps room; a misaligned pc goes
    // through IDLE so it lands in HALT rather than on the bus.
    if (state_q == S_WAIT && inst_data_ok && !redirect_valid) begin
      if (count_d < 2'd2 && pc_q[1:0] == 2'b00) begin
        state_d    = S_REQ;
        req_addr_d = pc_q;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= 2'd0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q alone qualifies the contents and
  // the outputs are forced to zero while it is empty.
  always_ff @(posedge clk) begin
    if (!redirect_valid) begin
      if (pop) begin
        fifo_q[0] <= (push && count_q == 2'd1) ? push_entry : fifo_q[1];
      end else if (push) begin
        fifo_q[count_q[0]] <= push_entry;
      end
    end
  end

  assign inst_req   = (state_q == S_REQ);
  assign inst_addr  = req_addr_q;
  assign id_valid   = (count_q != 2'd0);
  assign id_pc      = id_valid ? fifo_q[0].pc   : 32'h0;
  assign id_inst    = id_valid ? fifo_q[0].inst : 32'h0;
  assign id_adel    = id_valid && fifo_q[0].adel;
  assign id_op_code = id_inst[31:26];
  assign id_rt      = id_inst[20:16];
  assign id_funct   = id_inst[5:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the memory side is driven by hand, step by step,
// and outputs are sampled on the falling edge.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [5:0]  id_op_code;
  logic [4:0]  id_rt;
  logic [5:0]  id_funct;
  logic        id_adel;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] R0 = 32'h0085_3021;
  localparam logic [31:0] R1 = 32'h8C45_0004;
  localparam logic [31:0] R2 = 32'h1085_FFFF;
  localparam logic [31:0] R3 = 32'h2402_0001;
  localparam logic [31:0] R7 = 32'h0000_000C;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_op_code     (id_op_code),
    .id_rt          (id_rt),
    .id_funct       (id_funct),
    .id_adel        (id_adel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;

    step(); step();
    chk("rst_req", {31'h0, inst_req}, 32'h0);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_adel", {31'h0, id_adel}, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    rst = 1'b0;

    // Streaming fetch with one-cycle handshakes.
    step();
    chk("f0_req", {31'h0, inst_req}, 32'h1);
    chk("f0_addr", inst_addr, 32'hBFC0_0000);
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    chk("f0_wait_req", {31'h0, inst_req}, 32'h0);
    inst_data_ok = 1'b1; inst_rdata = R0;
    step();
    inst_data_ok = 1'b0;
    chk("f0_valid", {31'h0, id_valid}, 32'h1);
    chk("f0_pc", id_pc, 32'hBFC0_0000);
    chk("f0_inst", id_inst, R0);
    chk("f0_op", {26'h0, id_op_code}, 32'h0);
    chk("f0_rt", {27'h0, id_rt}, 32'h5);
    chk("f0_funct", {26'h0, id_funct}, 32'h21);
    chk("f1_req", {31'h0, inst_req}, 32'h1);
    chk("f1_addr", inst_addr, 32'hBFC0_0004);
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    chk("f0_popped", {31'h0, id_valid}, 32'h0);
    inst_data_ok = 1'b1; inst_rdata = R1;
    step();
    inst_data_ok = 1'b0;
    chk("f1_pc", id_pc, 32'hBFC0_0004);
    chk("f1_op", {26'h0, id_op_code}, 32'h23);
    chk("f2_req", {31'h0, inst_req}, 32'h1);
    chk("f2_addr", inst_addr, 32'hBFC0_0008);

    // Back-pressure: buffer fills to two, then fetching stops.
    id_ready = 1'b0;
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = R2;
    step();
    inst_data_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("full_no_req", {31'h0, inst_req}, 32'h0);
      step();
    end
    chk("full_valid", {31'h0, id_valid}, 32'h1);
    chk("full_head_pc", id_pc, 32'hBFC0_0004);
    chk("full_head_inst", id_inst, R1);
    id_ready = 1'b1;
    step();
    chk("drain_pc", id_pc, 32'hBFC0_0008);
    chk("drain_inst", id_inst, R2);
    chk("drain_no_req", {31'h0, inst_req}, 32'h0);
    step();
    chk("drain_empty", {31'h0, id_valid}, 32'h0);
    chk("f3_req", {31'h0, inst_req}, 32'h1);
    chk("f3_addr", inst_addr, 32'hBFC0_000C);

    // Redirect while the response is outstanding.
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    chk("rw_wait_req", {31'h0, inst_req}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    step();
    inst_data_ok = 1'b0;
    chk("rw_dropped", {31'h0, id_valid}, 32'h0);
    chk("rw_req", {31'h0, inst_req}, 32'h1);
    chk("rw_addr", inst_addr, 32'h8000_1000);
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = R3;
    step();
    inst_data_ok = 1'b0;
    chk("rw_valid", {31'h0, id_valid}, 32'h1);
    chk("rw_pc", id_pc, 32'h8000_1000);
    chk("rw_inst", id_inst, R3);
    chk("rw_next_addr", inst_addr, 32'h8000_1004);

    // Redirect while the request is held without addr_ok, coinciding with a pop.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    chk("rr_flushed", {31'h0, id_valid}, 32'h0);
    chk("rr_req_held", {31'h0, inst_req}, 32'h1);
    chk("rr_addr_held", inst_addr, 32'h8000_1004);
    step();
    chk("rr_addr_held2", inst_addr, 32'h8000_1004);
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    chk("rr_wait_req", {31'h0, inst_req}, 32'h0);
    inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
    step();
    inst_data_ok = 1'b0;
    chk("rr_dropped", {31'h0, id_valid}, 32'h0);
    chk("rr_req", {31'h0, inst_req}, 32'h1);
    chk("rr_addr", inst_addr, 32'h8000_1000);

    // Redirect to a misaligned pc together with data_ok.
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_F00D;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    id_ready = 1'b0;
    step();
    inst_data_ok = 1'b0; redirect_valid = 1'b0;
    chk("ma_dropped", {31'h0, id_valid}, 32'h0);
    chk("ma_no_req", {31'h0, inst_req}, 32'h0);
    step();
    chk("ma_valid", {31'h0, id_valid}, 32'h1);
    chk("ma_adel", {31'h0, id_adel}, 32'h1);
    chk("ma_inst", id_inst, 32'h0);
    chk("ma_pc", id_pc, 32'h8000_0002);
    chk("ma_req", {31'h0, inst_req}, 32'h0);
    step(); step(); step();
    chk("halt_no_req", {31'h0, inst_req}, 32'h0);
    chk("halt_valid", {31'h0, id_valid}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
    step();
    redirect_valid = 1'b0;
    chk("hr_flushed", {31'h0, id_valid}, 32'h0);
    chk("hr_adel", {31'h0, id_adel}, 32'h0);
    chk("hr_no_req", {31'h0, inst_req}, 32'h0);
    step();
    chk("hr_req", {31'h0, inst_req}, 32'h1);
    chk("hr_addr", inst_addr, 32'h8000_3000);

    // PC wrap at the top of the address space.
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'h0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    inst_data_ok = 1'b0; redirect_valid = 1'b0;
    chk("wr_no_req", {31'h0, inst_req}, 32'h0);
    step();
    chk("wr_req", {31'h0, inst_req}, 32'h1);
    chk("wr_addr", inst_addr, 32'hFFFF_FFFC);
    inst_addr_ok = 1'b1;
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = R7;
    step();
    inst_data_ok = 1'b0;
    chk("wr_valid", {31'h0, id_valid}, 32'h1);
    chk("wr_pc", id_pc, 32'hFFFF_FFFC);
    chk("wr_inst", id_inst, R7);
    chk("wr_next_req", {31'h0, inst_req}, 32'h1);
    chk("wr_next_addr", inst_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
